nemu_trace_buffer: RTL and testbench

Parametrised successor of the NEMU debug interface. It decodes NEMU stores to a tagged, word-aligned address window and keeps counter, eip, binary and string registers for waveform viewing. It adds a write-enable qualifier, byte-correct packing with length and truncation flags, an explicit clear command, and a show-ahead FIFO of {counter, eip} trace records that a debug reader drains by handshake. It sits beside the data-memory bus and observes CPU stores; it never stalls the CPU.

---
 rtl/nemu_trace_buffer.sv | 156 +++++++++++++++
 tb/tb_nemu_trace_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/nemu_trace_buffer.sv
// NEMU store-snooping debug buffer: decodes tagged stores into counter/eip/binary/string
// registers and queues {counter, eip} trace records in a show-ahead FIFO.
module nemu_trace_buffer #(
    parameter int unsigned      ADDR_W    = 30,
    parameter int unsigned      TAG_W     = 8,
    parameter logic [TAG_W-1:0] TAG_BASE  = 8'ha0,
    parameter int unsigned      BIN_BYTES = 10,
    parameter int unsigned      STR_BYTES = 32,
    parameter int unsigned      DEPTH     = 16,
    localparam int unsigned     BL_W      = $clog2(BIN_BYTES + 1),
    localparam int unsigned     SL_W      = $clog2(STR_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [31:0]            data,
    output logic [31:0]            counter,
    output logic [31:0]            eip,
    output logic [8*BIN_BYTES-1:0] binary,
    output logic [BL_W-1:0]        bin_len,
    output logic                   bin_trunc,
    output logic [8*STR_BYTES-1:0] str,
    output logic [SL_W-1:0]        str_len,
    output logic                   str_done,
    input  logic                   rd_en,
    output logic [63:0]            rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   overflow,
    output logic [15:0]            drop_cnt
);

    localparam int unsigned     IDX_W   = $clog2(DEPTH);
    localparam int unsigned     PTR_W   = IDX_W + 1;
    localparam logic [BL_W-1:0] BIN_MAX = BL_W'(BIN_BYTES);
    localparam logic [SL_W-1:0] STR_MAX = SL_W'(STR_BYTES);

    logic [TAG_W-1:0]       tag, off;
    logic                   cmd_counter, cmd_eip, cmd_bin, cmd_str, cmd_clear;
    logic                   push, pop, do_push, drop;

    logic [31:0]            counter_q, eip_q;
    logic [8*BIN_BYTES-1:0] binary_q;
    logic [BL_W-1:0]        bin_len_q;
    logic                   bin_trunc_q;
    logic [8*STR_BYTES-1:0] str_q;
    logic [SL_W-1:0]        str_len_q;
    logic                   str_done_q;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic                   overflow_q;
    logic [15:0]            drop_cnt_q;
    logic [63:0]            mem_q [DEPTH];

    assign tag = addr[ADDR_W-1 -: TAG_W];
    // Offset from the base tag; wraps, so tags below TAG_BASE land far outside 0..4.
    assign off = tag - TAG_BASE;

    always_comb begin
        cmd_counter = wr_en && (off == TAG_W'(0));
        cmd_eip     = wr_en && (off == TAG_W'(1));
        cmd_bin     = wr_en && (off == TAG_W'(2));
        cmd_str     = wr_en && (off == TAG_W'(3));
        cmd_clear   = wr_en && (off == TAG_W'(4));
    end

    assign rd_valid = (wr_ptr_q != rd_ptr_q);
    assign full     = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                      (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign push     = cmd_eip;
    assign pop      = rd_en && rd_valid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= {counter_q, data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q   <= '0;
            eip_q       <= '0;
            binary_q    <= '0;
            bin_len_q   <= '0;
            bin_trunc_q <= 1'b0;
            str_q       <= '0;
            str_len_q   <= '0;
            str_done_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else if (cmd_clear) begin
            counter_q   <= '0;
            eip_q       <= '0;
            binary_q    <= '0;
            bin_len_q   <= '0;
            bin_trunc_q <= 1'b0;
            str_q       <= '0;
            str_len_q   <= '0;
            str_done_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hffff) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (cmd_counter || cmd_eip) begin
                bin_len_q  <= '0;
                str_len_q  <= '0;
                str_done_q <= 1'b0;
            end
            if (cmd_counter) counter_q <= data;
            if (cmd_eip) eip_q <= data;
            if (cmd_bin) begin
                if (bin_len_q < BIN_MAX) begin
                    binary_q[8*bin_len_q +: 8] <= data[7:0];
                    bin_len_q                  <= bin_len_q + BL_W'(1);
                end else begin
                    bin_trunc_q <= 1'b1;
                end
            end
            if (cmd_str && !str_done_q) begin
                if (data[7:0] == 8'h00) begin
                    str_done_q <= 1'b1;
                end else if (str_len_q < STR_MAX) begin
                    str_q[8*str_len_q +: 8] <= data[7:0];
                    str_len_q               <= str_len_q + SL_W'(1);
                end else begin
                    str_done_q <= 1'b1;
                end
            end
        end
    end

    assign counter   = counter_q;
    assign eip       = eip_q;
    assign binary    = binary_q;
    assign bin_len   = bin_len_q;
    assign bin_trunc = bin_trunc_q;
    assign str       = str_q;
    assign str_len   = str_len_q;
    assign str_done  = str_done_q;
    assign rd_data   = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_nemu_trace_buffer.sv
// Directed bench for nemu_trace_buffer with default parameters.
module tb_nemu_trace_buffer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         wr_en = 1'b0;
    logic [29:0]  addr = '0;
    logic [31:0]  data = '0;
    logic         rd_en = 1'b0;
    logic [31:0]  counter, eip;
    logic [79:0]  binary;
    logic [3:0]   bin_len;
    logic         bin_trunc;
    logic [255:0] str;
    logic [5:0]   str_len;
    logic         str_done;
    logic [63:0]  rd_data;
    logic         rd_valid, full, overflow;
    logic [15:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    nemu_trace_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .addr      (addr),
        .data      (data),
        .counter   (counter),
        .eip       (eip),
        .binary    (binary),
        .bin_len   (bin_len),
        .bin_trunc (bin_trunc),
        .str       (str),
        .str_len   (str_len),
        .str_done  (str_done),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One store per cycle; called and returns at a negedge.
    task automatic wr(input logic [7:0] t, input logic [31:0] d);
        wr_en = 1'b1;
        addr  = {t, 22'h2a5};
        data  = d;
        @(negedge clk);
        wr_en = 1'b0;
        addr  = '0;
        data  = '0;
    endtask

    task automatic pop_check(input string tag, input logic [63:0] exp);
        chk({tag, "_valid"}, rd_valid, 1'b1);
        chk(tag, rd_data, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_counter"}, counter, 0);
        chk({tag, "_eip"}, eip, 0);
        chk({tag, "_binary"}, binary, 0);
        chk({tag, "_bin_len"}, bin_len, 0);
        chk({tag, "_bin_trunc"}, bin_trunc, 0);
        chk({tag, "_str"}, str, 0);
        chk({tag, "_str_len"}, str_len, 0);
        chk({tag, "_str_done"}, str_done, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Counter then eip, then a single pop.
        wr(8'ha0, 32'd5);
        wr(8'ha1, 32'h8000_0010);
        chk("counter", counter, 32'd5);
        chk("eip", eip, 32'h8000_0010);
        pop_check("first_rec", 64'h0000_0005_8000_0010);
        chk("empty_after_pop", rd_valid, 1'b0);

        // Binary truncation: 11 bytes into 10 slots.
        for (int i = 1; i <= 11; i++) wr(8'ha2, 32'(i));
        chk("binary", binary, 80'h0a09_0807_0605_0403_0201);
        chk("bin_len", bin_len, 4'd10);
        chk("bin_trunc", bin_trunc, 1'b1);

        // String with terminator; trailing byte ignored.
        wr(8'ha3, 32'h48);
        wr(8'ha3, 32'h69);
        wr(8'ha3, 32'h00);
        wr(8'ha3, 32'h58);
        chk("str", str, 256'h6948);
        chk("str_len", str_len, 6'd2);
        chk("str_done", str_done, 1'b1);
        wr(8'ha0, 32'd7);
        chk("str_len_cleared", str_len, 6'd0);
        chk("str_done_cleared", str_done, 1'b0);
        chk("str_kept", str, 256'h6948);
        chk("bin_len_cleared", bin_len, 4'd0);
        chk("binary_kept", binary, 80'h0a09_0807_0605_0403_0201);
        chk("bin_trunc_kept", bin_trunc, 1'b1);

        // Overflow: 17 pushes into 16 entries.
        for (int i = 1; i <= 17; i++) wr(8'ha1, 32'(i));
        chk("full", full, 1'b1);
        chk("overflow", overflow, 1'b1);
        chk("drop_cnt", drop_cnt, 16'd1);
        for (int i = 1; i <= 16; i++) pop_check("drain", {32'd7, 32'(i)});
        chk("drained", rd_valid, 1'b0);
        chk("not_full", full, 1'b0);

        // Refill, then push and pop together while full.
        for (int i = 1; i <= 16; i++) wr(8'ha1, 32'h100 + 32'(i));
        chk("refull", full, 1'b1);
        chk("refull_drop", drop_cnt, 16'd1);
        chk("refull_head", rd_data, {32'd7, 32'h101});
        rd_en = 1'b1;
        wr(8'ha1, 32'h111);
        rd_en = 1'b0;
        chk("pp_full", full, 1'b1);
        chk("pp_drop", drop_cnt, 16'd1);
        chk("pp_head", rd_data, {32'd7, 32'h102});

        // Clear with a concurrent pop request.
        rd_en = 1'b1;
        wr(8'ha4, 32'hffff_ffff);
        rd_en = 1'b0;
        chk_all_zero("clear");

        // Asynchronous reset in the middle of a string.
        wr(8'ha0, 32'd9);
        wr(8'ha1, 32'h55);
        wr(8'ha3, 32'h41);
        wr(8'ha3, 32'h42);
        chk("mid_str_len", str_len, 6'd2);
        chk("mid_rd_valid", rd_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Gated and foreign stores change nothing.
        addr  = {8'ha0, 22'h2a5};
        data  = 32'h1234;
        @(negedge clk);
        chk("gated_counter", counter, 32'd0);
        wr(8'ha5, 32'hdead);
        wr(8'h9f, 32'hbeef);
        chk_all_zero("foreign");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
